// File: rtl/nf_mem_arb.sv
// Two-port (IFU/LSU) arbiter onto a single-cycle-latency memory port.
// Define NF_ARB_RR_EN for round-robin contention; default is LSU priority with an IFU starvation guard.
module nf_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ack,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rvalid,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ack,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rvalid,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IFU  = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;

  logic [1:0] owner;
  logic       grant_ifu;
  logic       grant_lsu;
  logic       lsu_pick;

`ifdef NF_ARB_RR_EN
  // Last-grant register: 0 = IFU granted most recently, 1 = LSU.
  logic last_lsu;

  assign lsu_pick = !last_lsu;

  always_ff @(posedge clk) begin
    if (reset)
      last_lsu <= 1'b0;
    else if (grant_lsu)
      last_lsu <= 1'b1;
    else if (grant_ifu)
      last_lsu <= 1'b0;
  end
`else
  logic [3:0] starve_cnt;

  assign lsu_pick = (starve_cnt != 4'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_ifu || !ifu_req)
      starve_cnt <= '0;
    else if (grant_lsu)
      starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (!reset) begin
      if (ifu_req && lsu_req) begin
        grant_lsu = lsu_pick;
        grant_ifu = !lsu_pick;
      end else begin
        grant_ifu = ifu_req;
        grant_lsu = lsu_req;
      end
    end
  end

  assign ifu_ack   = grant_ifu;
  assign lsu_ack   = grant_lsu;
  assign mem_addr  = grant_lsu ? lsu_addr : ifu_addr;
  assign mem_we    = grant_lsu && lsu_we;
  assign mem_wdata = lsu_wdata;

  always_ff @(posedge clk) begin
    if (reset)
      owner <= OWN_NONE;
    else if (grant_ifu)
      owner <= OWN_IFU;
    else if (grant_lsu && !lsu_we)
      owner <= OWN_LSU;
    else
      owner <= OWN_NONE;
  end

  // Gating with reset drops a read whose data would return during reset.
  assign ifu_rvalid = (owner == OWN_IFU) && !reset;
  assign lsu_rvalid = (owner == OWN_LSU) && !reset;
  assign ifu_rdata  = mem_rdata;
  assign lsu_rdata  = mem_rdata;

endmodule
